sram_bus_master: RTL and testbench



---
 rtl/sram_pkg.sv | 25 ++
 rtl/sram_bus_master_if.sv | 31 +++
 rtl/sram_bus_master.sv | 151 +++++++++++++++
 tb/tb_sram_bus_master.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_pkg
// Brief    : Shared widths, wait-state defaults and FSM encoding for the
//            SRAM bus initiator.
// Revision : 1.0 - initial release
// ============================================================================
package sram_pkg;

    localparam int SRAM_AW     = 21;
    localparam int SRAM_DW     = 8;
    localparam int RD_WAIT_DEF = 2;
    localparam int WR_WAIT_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SETUP     = 3'd1,
        ST_RD_STROBE = 3'd2,
        ST_RD_DONE   = 3'd3,
        ST_WR_STROBE = 3'd4,
        ST_WR_HOLD   = 3'd5
    } sram_state_e;

endpackage
`default_nettype wire

// File: rtl/sram_bus_master_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_master_if
// Brief    : Single-beat request/acknowledge bus between core logic and the
//            SRAM initiator.
// Revision : 1.0 - initial release
// ============================================================================
interface sram_bus_master_if;
    import sram_pkg::*;

    logic               req;
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [SRAM_DW-1:0] wdata;
    logic               ready;
    logic               ack;
    logic [SRAM_DW-1:0] rdata;

    // master = requesting core logic, slave = the SRAM initiator
    modport master (
        output req, we, addr, wdata,
        input  ready, ack, rdata
    );

    modport slave (
        input  req, we, addr, wdata,
        output ready, ack, rdata
    );

endinterface
`default_nettype wire

// File: rtl/sram_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : sram_bus_master
// Brief    : Turns single-beat core requests into cycle-counted nCE/nOE/nWE
//            sequences on an asynchronous 21x8 SRAM bus.
// Revision : 1.0 - initial release
// ============================================================================
module sram_bus_master
    import sram_pkg::*;
#(
    parameter int RD_WAIT = RD_WAIT_DEF,
    parameter int WR_WAIT = WR_WAIT_DEF
) (
    input  wire logic               clk_sys,
    input  wire logic               reset,
    sram_bus_master_if.slave        bus,
    output logic [SRAM_AW-1:0]      SRAM_A,
    inout  wire  [SRAM_DW-1:0]      SRAM_DQ,
    output logic                    SRAM_nCE,
    output logic                    SRAM_nOE,
    output logic                    SRAM_nWE
);

    if (RD_WAIT < 1) begin : g_bad_rd_wait
        $error("sram_bus_master: RD_WAIT must be >= 1");
    end
    if (WR_WAIT < 1) begin : g_bad_wr_wait
        $error("sram_bus_master: WR_WAIT must be >= 1");
    end

    localparam logic [2:0] c_IDLE      = ST_IDLE;
    localparam logic [2:0] c_SETUP     = ST_SETUP;
    localparam logic [2:0] c_RD_STROBE = ST_RD_STROBE;
    localparam logic [2:0] c_RD_DONE   = ST_RD_DONE;
    localparam logic [2:0] c_WR_STROBE = ST_WR_STROBE;
    localparam logic [2:0] c_WR_HOLD   = ST_WR_HOLD;

    localparam int c_MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
    localparam int c_CW       = $clog2(c_MAX_WAIT + 1);
    localparam logic [c_CW-1:0] c_RD_LOAD = c_CW'(RD_WAIT - 1);
    localparam logic [c_CW-1:0] c_WR_LOAD = c_CW'(WR_WAIT - 1);
    localparam logic [c_CW-1:0] c_ONE     = c_CW'(1);

    logic [2:0]         r_state;
    logic [c_CW-1:0]    r_cnt;
    logic               r_we;
    logic [SRAM_AW-1:0] r_addr;
    logic [SRAM_DW-1:0] r_wdata;
    logic [SRAM_DW-1:0] r_rdata;
    logic               r_ready;
    logic               r_ack;
    logic               r_nce;
    logic               r_noe;
    logic               r_nwe;
    logic               r_dq_oe;

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_ready <= 1'b1;
            r_ack   <= 1'b0;
            r_nce   <= 1'b1;
            r_noe   <= 1'b1;
            r_nwe   <= 1'b1;
            r_dq_oe <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (bus.req) begin
                        r_we    <= bus.we;
                        r_addr  <= bus.addr;
                        r_wdata <= bus.wdata;
                        r_ready <= 1'b0;
                        r_nce   <= 1'b0;
                        // write data is on the bus a full cycle before nWE falls
                        r_dq_oe <= bus.we;
                        r_state <= c_SETUP;
                    end
                end
                c_SETUP: begin
                    if (r_we) begin
                        r_nwe   <= 1'b0;
                        r_cnt   <= c_WR_LOAD;
                        r_state <= c_WR_STROBE;
                    end else begin
                        r_noe   <= 1'b0;
                        r_cnt   <= c_RD_LOAD;
                        r_state <= c_RD_STROBE;
                    end
                end
                c_RD_STROBE: begin
                    if (r_cnt == '0) begin
                        r_rdata <= SRAM_DQ;
                        r_noe   <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= c_RD_DONE;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                c_RD_DONE: begin
                    r_nce   <= 1'b1;
                    r_ready <= 1'b1;
                    r_state <= c_IDLE;
                end
                c_WR_STROBE: begin
                    if (r_cnt == '0) begin
                        r_nwe   <= 1'b1;
                        r_ack   <= 1'b1;
                        r_state <= c_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - c_ONE;
                    end
                end
                c_WR_HOLD: begin
                    // data held through the nWE rising edge, released on IDLE entry
                    r_nce   <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= c_IDLE;
                end
                default: begin
                    r_nce   <= 1'b1;
                    r_noe   <= 1'b1;
                    r_nwe   <= 1'b1;
                    r_dq_oe <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign SRAM_DQ  = r_dq_oe ? r_wdata : {SRAM_DW{1'bz}};
    assign SRAM_A   = r_addr;
    assign SRAM_nCE = r_nce;
    assign SRAM_nOE = r_noe;
    assign SRAM_nWE = r_nwe;

    assign bus.ready = r_ready;
    assign bus.ack   = r_ack;
    assign bus.rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_bus_master
// Brief    : Self-checking bench for sram_bus_master at default and
//            RD_WAIT=5/WR_WAIT=1 settings, with a behavioural SRAM per DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_bus_master;
    import sram_pkg::*;

    typedef struct {
        int          dut;
        logic        we;
        logic [20:0] addr;
        logic [7:0]  wdata;
        int          lat;
        int          wt;
        logic [7:0]  rdata;
    } vec_t;

    logic clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;
    logic reset;

    logic        req_v   [2];
    logic        we_v    [2];
    logic [20:0] addr_v  [2];
    logic [7:0]  wdata_v [2];

    wire         ready_w [2];
    wire         ack_w   [2];
    wire  [7:0]  rdata_w [2];
    wire  [20:0] a_w     [2];
    wire         nce_w   [2];
    wire         noe_w   [2];
    wire         nwe_w   [2];
    wire  [7:0]  dq_r    [2];
    tri   [7:0]  dq0;
    tri   [7:0]  dq1;

    for (genvar b = 0; b < 8; b++) begin : g_pu
        pullup (dq0[b]);
        pullup (dq1[b]);
    end

    sram_bus_master_if u_if0 ();
    sram_bus_master_if u_if1 ();

    assign u_if0.req   = req_v[0];
    assign u_if0.we    = we_v[0];
    assign u_if0.addr  = addr_v[0];
    assign u_if0.wdata = wdata_v[0];
    assign u_if1.req   = req_v[1];
    assign u_if1.we    = we_v[1];
    assign u_if1.addr  = addr_v[1];
    assign u_if1.wdata = wdata_v[1];
    assign ready_w[0]  = u_if0.ready;
    assign ack_w[0]    = u_if0.ack;
    assign rdata_w[0]  = u_if0.rdata;
    assign ready_w[1]  = u_if1.ready;
    assign ack_w[1]    = u_if1.ack;
    assign rdata_w[1]  = u_if1.rdata;

    sram_bus_master u_dut0 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .bus      (u_if0),
        .SRAM_A   (a_w[0]),
        .SRAM_DQ  (dq0),
        .SRAM_nCE (nce_w[0]),
        .SRAM_nOE (noe_w[0]),
        .SRAM_nWE (nwe_w[0])
    );

    sram_bus_master #(.RD_WAIT(5), .WR_WAIT(1)) u_dut1 (
        .clk_sys  (clk_sys),
        .reset    (reset),
        .bus      (u_if1),
        .SRAM_A   (a_w[1]),
        .SRAM_DQ  (dq1),
        .SRAM_nCE (nce_w[1]),
        .SRAM_nOE (noe_w[1]),
        .SRAM_nWE (nwe_w[1])
    );

    // Behavioural SRAM: drives DQ while selected with nOE low, stores on nWE low.
    logic [7:0] mem [2][256];
    int         contention = 0;

    assign dq0 = (!nce_w[0] && !noe_w[0]) ? mem[0][a_w[0][7:0]] : 8'bz;
    assign dq1 = (!nce_w[1] && !noe_w[1]) ? mem[1][a_w[1][7:0]] : 8'bz;
    assign dq_r[0] = dq0;
    assign dq_r[1] = dq1;

    always @(negedge clk_sys) begin
        for (int i = 0; i < 2; i++) begin
            if (!noe_w[i] && !nwe_w[i]) contention++;
            if (!nce_w[i] && !noe_w[i] && dq_r[i] !== mem[i][a_w[i][7:0]]) contention++;
            if (!nce_w[i] && !nwe_w[i]) mem[i][a_w[i][7:0]] = dq_r[i];
        end
    end

    int         n_chk = 0;
    int         n_pass = 0;
    logic [7:0] last_rd [2];
    vec_t       vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic wait_ready(input int d);
        int n = 0;
        while (!ready_w[d] && n < 50) begin
            @(negedge clk_sys);
            n++;
        end
        if (n >= 50) chk("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic run_txn(input vec_t v, input bit toggle, input string name);
        int d = v.dut;
        int ack_cyc = -1, rdy_cyc = -1, acks = 0, both = 0;
        int oe_lo = 0, we_lo = 0, a_bad = 0, dq_bad = 0;
        logic [7:0] rd_at_ack = 8'h00;
        wait_ready(d);
        req_v[d] = 1'b1; we_v[d] = v.we; addr_v[d] = v.addr; wdata_v[d] = v.wdata;
        for (int c = 1; c <= v.lat + 3; c++) begin
            @(negedge clk_sys);
            if (ack_w[d]) begin acks++; if (ack_cyc < 0) ack_cyc = c; end
            if (ready_w[d] && rdy_cyc < 0) rdy_cyc = c;
            if (ack_w[d] && ready_w[d]) both++;
            if (!noe_w[d]) oe_lo++;
            if (!nwe_w[d]) we_lo++;
            if (a_w[d] !== v.addr) a_bad++;
            if (c <= v.lat && nce_w[d] !== 1'b0) a_bad++;
            if (v.we) begin
                if (c <= v.lat && dq_r[d] !== v.wdata) dq_bad++;
                if (c >  v.lat && dq_r[d] !== 8'hFF)   dq_bad++;
            end else if (noe_w[d] && dq_r[d] !== 8'hFF) dq_bad++;
            if (c == v.lat) rd_at_ack = rdata_w[d];
            // scramble captured inputs; optionally pulse req while busy
            addr_v[d] = ~v.addr; wdata_v[d] = ~v.wdata; we_v[d] = ~v.we;
            req_v[d]  = toggle && (c < v.lat) && (c % 2 == 1);
        end
        if (!v.we) last_rd[d] = v.rdata;
        chk({name, "_ack_cyc"},   ack_cyc, v.lat);
        chk({name, "_ready_cyc"}, rdy_cyc, v.lat + 1);
        chk({name, "_ack_count"}, acks, 1);
        chk({name, "_ack_ready"}, both, 0);
        chk({name, "_noe_low"},   oe_lo, v.we ? 0 : v.wt);
        chk({name, "_nwe_low"},   we_lo, v.we ? v.wt : 0);
        chk({name, "_addr_nce"},  a_bad, 0);
        chk({name, "_dq"},        dq_bad, 0);
        chk({name, "_rdata_ack"}, {24'd0, rd_at_ack}, {24'd0, last_rd[d]});
        chk({name, "_rdata_end"}, {24'd0, rdata_w[d]}, {24'd0, last_rd[d]});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 1'b1, 21'h1ABCD,  8'h5A, 4, 2, 8'h00};
        vecs[1] = '{0, 1'b0, 21'h1ABCD,  8'h00, 4, 2, 8'h5A};
        vecs[2] = '{0, 1'b1, 21'h00010,  8'hC3, 4, 2, 8'h00};
        vecs[3] = '{0, 1'b1, 21'h1FFFFF, 8'h81, 4, 2, 8'h00};
        vecs[4] = '{0, 1'b0, 21'h00010,  8'h00, 4, 2, 8'hC3};
        vecs[5] = '{0, 1'b0, 21'h1FFFFF, 8'h00, 4, 2, 8'h81};
        vecs[6] = '{1, 1'b1, 21'h1FF20,  8'hA5, 3, 1, 8'h00};
        vecs[7] = '{1, 1'b0, 21'h1FF20,  8'h00, 7, 5, 8'hA5};
        vecs[8] = '{1, 1'b1, 21'h00033,  8'h00, 3, 1, 8'h00};
        vecs[9] = '{1, 1'b0, 21'h00033,  8'hFF, 7, 5, 8'h00};

        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_v[i] = 1'b0; we_v[i] = 1'b0; addr_v[i] = '0; wdata_v[i] = '0;
            last_rd[i] = 8'h00;
        end
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        reset = 1'b0;

        // Idle after reset: ready=1, ack=0, strobes high, DQ released, rdata=0
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_sys);
            for (int d = 0; d < 2; d++)
                chk($sformatf("idle_d%0d_c%0d", d, c),
                    {11'd0, ready_w[d], ack_w[d], nce_w[d], noe_w[d], nwe_w[d], dq_r[d], rdata_w[d]},
                    {11'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00});
        end
        chk("idle_addr_d0", {11'd0, a_w[0]}, 32'd0);
        chk("idle_addr_d1", {11'd0, a_w[1]}, 32'd0);

        for (int i = 0; i < 10; i++) run_txn(vecs[i], 1'b0, $sformatf("v%0d", i));

        // Write then read with req held high across both transactions
        begin
            int ack1 = -1, ack2 = -1, rdy = -1, noe_first = -1, rel = -1, acc2 = -1;
            wait_ready(0);
            req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 21'h00055; wdata_v[0] = 8'h3C;
            for (int c = 1; c <= 14; c++) begin
                @(negedge clk_sys);
                if (ack_w[0]) begin
                    if (ack1 < 0) ack1 = c; else if (ack2 < 0) ack2 = c;
                end
                if (ready_w[0] && rdy < 0) rdy = c;
                if (!noe_w[0] && noe_first < 0) noe_first = c;
                if (c > 1 && noe_w[0] && dq_r[0] === 8'hFF && rel < 0) rel = c;
                if (ready_w[0] && req_v[0] && acc2 < 0) acc2 = c;
                if (c == 1) begin we_v[0] = 1'b0; wdata_v[0] = 8'h00; end
                if (acc2 >= 0 && c > acc2) req_v[0] = 1'b0;
            end
            last_rd[0] = 8'h3C;
            chk("b2b_wr_ack",     ack1, 4);
            chk("b2b_ready",      rdy, 5);
            chk("b2b_accept2",    acc2, 5);
            chk("b2b_dq_release", rel, 5);
            chk("b2b_noe_fall",   noe_first, 7);
            chk("b2b_turnaround", (noe_first - rel >= 2) ? 32'd1 : 32'd0, 32'd1);
            chk("b2b_rd_ack",     ack2, 9);
            chk("b2b_rdata",      {24'd0, rdata_w[0]}, 32'h3C);
        end

        // Reset asserted in WR_STROBE aborts the write with no ack
        wait_ready(0);
        req_v[0] = 1'b1; we_v[0] = 1'b1; addr_v[0] = 21'h00044; wdata_v[0] = 8'h77;
        @(negedge clk_sys);
        req_v[0] = 1'b0;
        @(negedge clk_sys);
        chk("rst_pre_nwe", {31'd0, nwe_w[0]}, 32'd0);
        reset = 1'b1;
        @(negedge clk_sys);
        chk("rst_vals",
            {11'd0, ready_w[0], ack_w[0], nce_w[0], noe_w[0], nwe_w[0], dq_r[0], rdata_w[0]},
            {11'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'hFF, 8'h00});
        chk("rst_addr", {11'd0, a_w[0]}, 32'd0);
        reset = 1'b0;
        last_rd[0] = 8'h00;
        last_rd[1] = 8'h00;
        @(negedge clk_sys);
        chk("rst_no_ack", {31'd0, ack_w[0]}, 32'd0);
        run_txn(vecs[1], 1'b0, "rst_rd");

        // req pulsing while busy must not start extra transactions
        run_txn(vecs[7], 1'b1, "tog_rd");
        run_txn('{1, 1'b1, 21'h00066, 8'h99, 3, 1, 8'h00}, 1'b1, "tog_wr");

        chk("no_contention", contention, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
